// File: rtl/scan_ctrl_pkg.sv
// scan_ctrl_pkg: shared FSM state type and default chain length for the scan controller.
package scan_ctrl_pkg;
    localparam int CHAIN_LEN_DEFAULT = 32;
    typedef enum logic [2:0] {IDLE, LOAD, CAPTURE, UNLOAD, DONE} state_t;
endpackage

// File: rtl/scan_ctrl_if.sv
// scan_ctrl_if: request, scan-chain and response signals of the scan controller.
interface scan_ctrl_if #(parameter int CHAIN_LEN = scan_ctrl_pkg::CHAIN_LEN_DEFAULT);
    logic                 start_valid;
    logic                 start_ready;
    logic [CHAIN_LEN-1:0] pattern_in;
    logic [CHAIN_LEN-1:0] expect_in;
    logic                 test_mode;
    logic                 scan_en;
    logic                 scan_in0;
    logic                 scan_out0;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [CHAIN_LEN-1:0] resp_data;
    logic                 mismatch;
    modport master (
        output start_valid, pattern_in, expect_in, scan_out0, resp_ready,
        input  start_ready, test_mode, scan_en, scan_in0, resp_valid, resp_data, mismatch
    );
    modport slave (
        input  start_valid, pattern_in, expect_in, scan_out0, resp_ready,
        output start_ready, test_mode, scan_en, scan_in0, resp_valid, resp_data, mismatch
    );
endinterface

// File: rtl/scan_ctrl_sreg.sv
// scan_ctrl_sreg: parallel-load shift register; shifts toward bit 0, serial input enters at the MSB.
module scan_ctrl_sreg #(parameter int W = 8) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         shift,
    input  logic         sin,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or posedge reset)
        if (reset) q <= '0;
        else if (load) q <= d;
        else if (shift) q <= {sin, q[W-1:1]};
endmodule

// File: rtl/scan_ctrl.sv
// scan_ctrl: loads a pattern into a scan chain, captures once, and unloads the response.
// Optional macro SCAN_CTRL_COMPARE_EN enables the response-vs-expect mismatch flag.
module scan_ctrl
    import scan_ctrl_pkg::*;
#(
    parameter int CHAIN_LEN = CHAIN_LEN_DEFAULT
) (
    input logic        clk,
    input logic        reset,
    scan_ctrl_if.slave bus
);
    localparam int CW = $clog2(CHAIN_LEN);
    localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);
    state_t               state;
    logic [CW-1:0]        cnt;
    logic [CHAIN_LEN-1:0] stim_q, resp_q;
    logic                 start_ready, test_mode, scan_en, resp_valid, mismatch, miss_next;
    logic                 accept, last, load_phase, unload_phase, unused_stim;
    assign accept       = state == IDLE && bus.start_valid;
    assign last         = cnt == LAST;
    assign load_phase   = state == LOAD;
    assign unload_phase = state == UNLOAD;
    // Zeros shift in behind the pattern, so bit 0 reads 0 outside LOAD without gating.
    scan_ctrl_sreg #(.W(CHAIN_LEN)) u_stim (
        .clk(clk), .reset(reset), .load(accept), .shift(load_phase),
        .sin(1'b0), .d(bus.pattern_in), .q(stim_q)
    );
    scan_ctrl_sreg #(.W(CHAIN_LEN)) u_resp (
        .clk(clk), .reset(reset), .load(accept), .shift(unload_phase),
        .sin(bus.scan_out0), .d('0), .q(resp_q)
    );
    assign unused_stim = ^stim_q[CHAIN_LEN-1:1];
`ifdef SCAN_CTRL_COMPARE_EN
    logic [CHAIN_LEN-1:0] expect_q;
    always_ff @(posedge clk or posedge reset)
        if (reset) expect_q <= '0;
        else if (accept) expect_q <= bus.expect_in;
    // Compare against the word the final UNLOAD edge is about to store.
    assign miss_next = {bus.scan_out0, resp_q[CHAIN_LEN-1:1]} != expect_q;
`else
    assign miss_next = 1'b0;
`endif
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            start_ready <= 1'b1;
            scan_en     <= 1'b0;
            test_mode   <= 1'b0;
            resp_valid  <= 1'b0;
            mismatch    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start_valid) begin
                    state       <= LOAD;
                    cnt         <= '0;
                    start_ready <= 1'b0;
                    scan_en     <= 1'b1;
                    test_mode   <= 1'b1;
                end
                LOAD: if (last) begin
                    state   <= CAPTURE;
                    cnt     <= '0;
                    scan_en <= 1'b0;
                end else cnt <= cnt + 1'b1;
                CAPTURE: begin
                    state   <= UNLOAD;
                    cnt     <= '0;
                    scan_en <= 1'b1;
                end
                UNLOAD: if (last) begin
                    state      <= DONE;
                    cnt        <= '0;
                    scan_en    <= 1'b0;
                    test_mode  <= 1'b0;
                    resp_valid <= 1'b1;
                    mismatch   <= miss_next;
                end else cnt <= cnt + 1'b1;
                DONE: if (bus.resp_ready) begin
                    state       <= IDLE;
                    start_ready <= 1'b1;
                    resp_valid  <= 1'b0;
                    mismatch    <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.start_ready = start_ready;
    assign bus.scan_en     = scan_en;
    assign bus.test_mode   = test_mode;
    assign bus.scan_in0    = stim_q[0];
    assign bus.resp_valid  = resp_valid;
    assign bus.resp_data   = resp_q;
    assign bus.mismatch    = mismatch;
endmodule

// File: doc/scan_ctrl.md
SCAN_CTRL -- requirements
Module: scan_ctrl

Interface
REQ-001 Parameter: CHAIN_LEN, default 32, number of flops in the attached scan chain (legal range 2..1024).
REQ-002 Port: clk  input  1  system clock; all logic on rising edge.
REQ-003 Port: reset  input  1  system reset, asynchronous, active-high.
REQ-004 Port: start_valid  input  1  request to run one scan pattern.
REQ-005 Port: start_ready  output  1  controller can accept a request (IDLE only).
REQ-006 Port: pattern_in  input  CHAIN_LEN  stimulus word; bit 0 shifted first.
REQ-007 Port: expect_in  input  CHAIN_LEN  expected response word, used only with the compare feature.
REQ-008 Port: test_mode  output  1  test mode select to chain.
REQ-009 Port: scan_en  output  1  scan shift enable to chain.
REQ-010 Port: scan_in0  output  1  serial data into chain.
REQ-011 Port: scan_out0  input  1  serial data from chain.
REQ-012 Port: resp_valid  output  1  captured response available.
REQ-013 Port: resp_ready  input  1  consumer accepts response.
REQ-014 Port: resp_data  output  CHAIN_LEN  unloaded response; first bit observed on scan_out0 in bit 0.
REQ-015 Port: mismatch  output  1  resp_data differs from expect_in latched at start.

Function
REQ-016 States: IDLE, LOAD, CAPTURE, UNLOAD, DONE; single FSM.
REQ-017 IDLE: start_ready=1; start_valid&&start_ready latches pattern_in and expect_in and moves to LOAD.
REQ-018 LOAD: exactly CHAIN_LEN cycles; scan_en=1, test_mode=1, scan_in0 = latched pattern bit k in LOAD cycle k (k=0..CHAIN_LEN-1); scan_out0 ignored.
REQ-019 CAPTURE: exactly 1 cycle; scan_en=0, test_mode=1, scan_in0=0.
REQ-020 UNLOAD: exactly CHAIN_LEN cycles; scan_en=1, test_mode=1, scan_in0=0; scan_out0 sampled at the rising edge ending UNLOAD cycle k into response bit k.
REQ-021 DONE: resp_valid=1, resp_data and mismatch stable; resp_valid&&resp_ready returns to IDLE the next cycle.
REQ-022 Latency: handshake at cycle 0 -> resp_valid first high at cycle 2*CHAIN_LEN+2.
REQ-023 start_valid outside IDLE is ignored; no queuing; pattern registers unchanged.
REQ-024 resp_ready outside DONE has no effect; resp_valid never drops before acceptance.
REQ-025 Bit counter width = ceil(log2(CHAIN_LEN)); counts 0..CHAIN_LEN-1, clears on every state change, never wraps within a phase.
REQ-026 In IDLE and DONE: scan_en=0, test_mode=0, scan_in0=0.
REQ-027 Back-to-back: acceptance in DONE then start_valid held -> new request accepted in the first IDLE cycle.

Reset
REQ-028 reset asserted at any time (including mid-LOAD/UNLOAD) forces IDLE asynchronously; partial pattern discarded.
REQ-029 Reset values: start_ready=1, scan_en=0, test_mode=0, scan_in0=0, resp_valid=0, resp_data=0, mismatch=0; counter 0.

Configuration
REQ-030 Macro SCAN_CTRL_COMPARE_EN: when defined, mismatch = (resp_data != latched expect_in), registered on entry to DONE.
REQ-031 Without SCAN_CTRL_COMPARE_EN: expect_in unused and not latched, mismatch tied to 0; all other behaviour identical.

Structure
REQ-032 Package scan_ctrl_pkg holds state enum type and default CHAIN_LEN constant.
REQ-033 One sub-module scan_ctrl_sreg: CHAIN_LEN-bit parallel-load / serial-in-out shift register, instanced twice (stimulus, response).

Verification
REQ-034 Bench models chain as CHAIN_LEN=8 shift register whose CAPTURE loads bitwise-inverted contents.
REQ-035 Reset, then pattern_in=8'hA5 -> scan_in0 sequence 1,0,1,0,0,1,0,1 over 8 LOAD cycles; resp_data=8'h5A at cycle 18.
REQ-036 expect_in=8'h5A with macro -> mismatch=0; expect_in=8'h00 -> mismatch=1; without macro mismatch=0 in both.
REQ-037 resp_ready held low 20 cycles in DONE -> resp_valid and resp_data stable; start_valid pulses in that window ignored.
REQ-038 Assert reset at LOAD cycle 3 -> next edge all outputs at reset values; following request 8'h3C completes normally with 8'hC3.
REQ-039 start_valid held continuously with resp_ready=1 -> patterns 8'h01,8'hFF accepted 19 cycles apart, responses 8'hFE, 8'h00.
